// File: rtl/sram_sched_pkg.sv
// Shared types and default constants for the SRAM scheduler.
package sram_sched_pkg;

  typedef enum logic [1:0] {
    PORT_VRAM  = 2'd0,
    PORT_SDRAM = 2'd1,
    PORT_MCR   = 2'd2
  } port_e;

  typedef enum logic [1:0] {
    WC_IDLE  = 2'd0,
    WC_XFER  = 2'd1,
    WC_RECOV = 2'd2
  } wc_state_e;

  localparam int          DEF_ACCESS_CYCLES = 2;
  localparam int          DEF_STARVE_LIMIT  = 8;
  localparam logic [17:0] DEF_VRAM_BASE     = 18'h38000;
  localparam logic [17:0] DEF_MCR_BASE      = 18'h30000;

  // Fixed rotation order vram -> sdram -> mcr -> vram.
  function automatic port_e next_port(input port_e p);
    case (p)
      PORT_VRAM:  return PORT_SDRAM;
      PORT_SDRAM: return PORT_MCR;
      default:    return PORT_VRAM;
    endcase
  endfunction

  // First pending port found when scanning from 'first' in rotation order.
  function automatic port_e rr_pick(input logic [2:0] pend, input port_e first);
    port_e p;
    port_e pick;
    logic  found;
    p     = first;
    pick  = first;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && pend[p]) begin
        pick  = p;
        found = 1'b1;
      end
      p = next_port(p);
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_sched_if.sv
// Requester-side bundle: the three request/response ports of the scheduler.
interface sram_sched_if;
  import sram_sched_pkg::*;

  logic [11:0] mcr_addr;
  logic [51:0] mcr_data_in;
  logic [51:0] mcr_data_out;
  logic        mcr_req;
  logic        mcr_write;
  logic        mcr_ready;
  logic        mcr_done;

  logic [17:0] sdram_addr;
  logic [31:0] sdram_data_in;
  logic [31:0] sdram_data_out;
  logic        sdram_req;
  logic        sdram_write;
  logic        sdram_ready;
  logic        sdram_done;

  logic [14:0] vram_addr;
  logic [31:0] vram_data_out;
  logic        vram_req;
  logic        vram_ready;
  logic        vram_done;

  modport master (
    output mcr_addr, mcr_data_in, mcr_req, mcr_write,
    input  mcr_data_out, mcr_ready, mcr_done,
    output sdram_addr, sdram_data_in, sdram_req, sdram_write,
    input  sdram_data_out, sdram_ready, sdram_done,
    output vram_addr, vram_req,
    input  vram_data_out, vram_ready, vram_done
  );

  modport slave (
    input  mcr_addr, mcr_data_in, mcr_req, mcr_write,
    output mcr_data_out, mcr_ready, mcr_done,
    input  sdram_addr, sdram_data_in, sdram_req, sdram_write,
    output sdram_data_out, sdram_ready, sdram_done,
    input  vram_addr, vram_req,
    output vram_data_out, vram_ready, vram_done
  );
endinterface

// File: rtl/sram_word_cycle.sv
// One 32-bit SRAM word transfer: IDLE -> XFER (ACCESS_CYCLES clocks) -> RECOV (1 clock).
// All pin strobes are registered. A new start is taken in IDLE or RECOV so words can run
// back-to-back; busy covers XFER only. rdata_o is the live pin data, to be sampled on the
// edge that ends the XFER clock flagged by last_o.
//
// state    | meaning
// WC_IDLE  | bus released, waiting for start
// WC_XFER  | address stable, both chips selected, read or write strobes active
// WC_RECOV | all strobes high, bus released for one clock
module sram_word_cycle
  import sram_sched_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [17:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        write_i,
  input  logic [31:0] io_i,
  output logic        busy_o,
  output logic        last_o,
  output logic [31:0] rdata_o,
  output logic [17:0] sram_a_o,
  output logic        ce_n_o,
  output logic        oe_n_o,
  output logic        we_n_o,
  output logic        io_oe_o,
  output logic [31:0] io_wdata_o
);

  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] CNT_WE_END = CW'(ACCESS_CYCLES - 2);

  wc_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [17:0] a_q;
  logic        ce_n_q, oe_n_q, we_n_q, drv_q;

  // Word transfer sequencer with registered pin strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WC_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      a_q     <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      case (state_q)
        WC_XFER: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= WC_RECOV;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drv_q   <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            // write strobe stays low through XFER index ACCESS_CYCLES-2, leaving a hold clock
            we_n_q <= !(write_q && (cnt_q < CNT_WE_END));
          end
        end
        default: begin
          if (start_i) begin
            state_q <= WC_XFER;
            cnt_q   <= '0;
            a_q     <= addr_i;
            wdata_q <= wdata_i;
            write_q <= write_i;
            ce_n_q  <= 1'b0;
            oe_n_q  <= write_i;
            we_n_q  <= !write_i;
            drv_q   <= write_i;
          end else begin
            state_q <= WC_IDLE;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drv_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o     = (state_q == WC_XFER);
  assign last_o     = (state_q == WC_XFER) && (cnt_q == CNT_LAST);
  assign rdata_o    = io_i;
  assign sram_a_o   = a_q;
  assign ce_n_o     = ce_n_q;
  assign oe_n_o     = oe_n_q;
  assign we_n_o     = we_n_q;
  assign io_oe_o    = drv_q;
  assign io_wdata_o = wdata_q;

endmodule

// File: rtl/sram_sched.sv
// Three-port scheduler for the shared 256K x 32 SRAM (two x16 chips).
// Holds per-port pending requests, the vram age counter, the round-robin arbiter
// and the two-word microcode sequencing; pin cycles come from sram_word_cycle.
module sram_sched
  import sram_sched_pkg::*;
#(
  parameter int          ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int          STARVE_LIMIT  = DEF_STARVE_LIMIT,
  parameter logic [17:0] VRAM_BASE     = DEF_VRAM_BASE,
  parameter logic [17:0] MCR_BASE      = DEF_MCR_BASE
) (
  input  logic        clk,
  input  logic        reset,
  sram_sched_if.slave bus,
  output logic [17:0] sram_a,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  inout  wire  [15:0] sram1_io,
  inout  wire  [15:0] sram2_io,
  output logic        sram1_ce_n,
  output logic        sram1_ub_n,
  output logic        sram1_lb_n,
  output logic        sram2_ce_n,
  output logic        sram2_ub_n,
  output logic        sram2_lb_n
);

  logic [2:0]  pend_q, done_q;
  logic [7:0]  age_q, age_d;
  port_e       rr_q, owner_q, grant;
  logic        active_q, mcr_phase_q, mcr_hi_q;
  logic [11:0] mcr_addr_q;
  logic [51:0] mcr_wdata_q, mcr_rdata_q;
  logic        mcr_write_q;
  logic [31:0] mcr_lo_q;
  logic [17:0] sd_addr_q;
  logic [31:0] sd_wdata_q, sd_rdata_q;
  logic        sd_write_q;
  logic [14:0] vr_addr_q;
  logic [31:0] vr_rdata_q;

  logic        grant_fire, wc_start, wc_write, wc_busy, wc_last, wc_io_oe;
  logic [17:0] wc_addr, mcr_lo_addr;
  logic [31:0] wc_wdata, wc_rdata, wc_io_wdata;

  assign mcr_lo_addr = MCR_BASE + {5'b0, mcr_addr_q, 1'b0};

  // Arbitration and word-cycle request mux; the mcr high word bypasses arbitration.
  always_comb begin
    if (pend_q[PORT_VRAM] && (age_q >= 8'(STARVE_LIMIT))) grant = PORT_VRAM;
    else                                                  grant = rr_pick(pend_q, rr_q);
    grant_fire = !active_q && !wc_busy && (|pend_q);
    wc_start   = mcr_hi_q || grant_fire;
    wc_addr    = '0;
    wc_wdata   = '0;
    wc_write   = 1'b0;
    if (mcr_hi_q) begin
      wc_addr  = mcr_lo_addr + 18'd1;
      wc_wdata = {12'b0, mcr_wdata_q[51:32]};
      wc_write = mcr_write_q;
    end else begin
      case (grant)
        PORT_VRAM: wc_addr = VRAM_BASE + {3'b0, vr_addr_q};
        PORT_SDRAM: begin
          wc_addr  = sd_addr_q;
          wc_wdata = sd_wdata_q;
          wc_write = sd_write_q;
        end
        default: begin
          wc_addr  = mcr_lo_addr;
          wc_wdata = mcr_wdata_q[31:0];
          wc_write = mcr_write_q;
        end
      endcase
    end
  end

  // vram wait age, saturating, cleared whenever no vram request is pending.
  always_comb begin
    age_d = age_q;
    if (!pend_q[PORT_VRAM])  age_d = '0;
    else if (age_q != 8'hFF) age_d = age_q + 8'd1;
  end

  // Request capture, grant bookkeeping, mcr word sequencing and completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      done_q      <= '0;
      age_q       <= '0;
      rr_q        <= PORT_VRAM;
      owner_q     <= PORT_VRAM;
      active_q    <= 1'b0;
      mcr_phase_q <= 1'b0;
      mcr_hi_q    <= 1'b0;
      mcr_addr_q  <= '0;
      mcr_wdata_q <= '0;
      mcr_write_q <= 1'b0;
      mcr_lo_q    <= '0;
      mcr_rdata_q <= '0;
      sd_addr_q   <= '0;
      sd_wdata_q  <= '0;
      sd_write_q  <= 1'b0;
      sd_rdata_q  <= '0;
      vr_addr_q   <= '0;
      vr_rdata_q  <= '0;
    end else begin
      done_q   <= '0;
      mcr_hi_q <= 1'b0;
      age_q    <= age_d;
      if (!pend_q[PORT_VRAM] && bus.vram_req) begin
        pend_q[PORT_VRAM] <= 1'b1;
        vr_addr_q         <= bus.vram_addr;
      end
      if (!pend_q[PORT_SDRAM] && bus.sdram_req) begin
        pend_q[PORT_SDRAM] <= 1'b1;
        sd_addr_q          <= bus.sdram_addr;
        sd_wdata_q         <= bus.sdram_data_in;
        sd_write_q         <= bus.sdram_write;
      end
      if (!pend_q[PORT_MCR] && bus.mcr_req) begin
        pend_q[PORT_MCR] <= 1'b1;
        mcr_addr_q       <= bus.mcr_addr;
        mcr_wdata_q      <= bus.mcr_data_in;
        mcr_write_q      <= bus.mcr_write;
      end
      if (grant_fire) begin
        active_q    <= 1'b1;
        owner_q     <= grant;
        rr_q        <= next_port(grant);
        mcr_phase_q <= 1'b0;
      end
      if (active_q && wc_last) begin
        if (owner_q == PORT_MCR && !mcr_phase_q) begin
          mcr_lo_q    <= wc_rdata;
          mcr_phase_q <= 1'b1;
          mcr_hi_q    <= 1'b1;
        end else begin
          active_q        <= 1'b0;
          pend_q[owner_q] <= 1'b0;
          done_q[owner_q] <= 1'b1;
          case (owner_q)
            PORT_VRAM:  vr_rdata_q <= wc_rdata;
            PORT_SDRAM: if (!sd_write_q) sd_rdata_q <= wc_rdata;
            default:    if (!mcr_write_q) mcr_rdata_q <= {wc_rdata[19:0], mcr_lo_q};
          endcase
        end
      end
    end
  end

  sram_word_cycle #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_word (
    .clk        (clk),
    .reset      (reset),
    .start_i    (wc_start),
    .addr_i     (wc_addr),
    .wdata_i    (wc_wdata),
    .write_i    (wc_write),
    .io_i       ({sram2_io, sram1_io}),
    .busy_o     (wc_busy),
    .last_o     (wc_last),
    .rdata_o    (wc_rdata),
    .sram_a_o   (sram_a),
    .ce_n_o     (sram1_ce_n),
    .oe_n_o     (sram_oe_n),
    .we_n_o     (sram_we_n),
    .io_oe_o    (wc_io_oe),
    .io_wdata_o (wc_io_wdata)
  );

  assign sram1_io   = wc_io_oe ? wc_io_wdata[15:0]  : 16'bz;
  assign sram2_io   = wc_io_oe ? wc_io_wdata[31:16] : 16'bz;
  assign sram2_ce_n = sram1_ce_n;
  assign sram1_ub_n = 1'b0;
  assign sram1_lb_n = 1'b0;
  assign sram2_ub_n = 1'b0;
  assign sram2_lb_n = 1'b0;

  assign bus.vram_ready     = !pend_q[PORT_VRAM];
  assign bus.sdram_ready    = !pend_q[PORT_SDRAM];
  assign bus.mcr_ready      = !pend_q[PORT_MCR];
  assign bus.vram_done      = done_q[PORT_VRAM];
  assign bus.sdram_done     = done_q[PORT_SDRAM];
  assign bus.mcr_done       = done_q[PORT_MCR];
  assign bus.vram_data_out  = vr_rdata_q;
  assign bus.sdram_data_out = sd_rdata_q;
  assign bus.mcr_data_out   = mcr_rdata_q;

endmodule

// File: tb/tb_sram_sched.sv
// Directed bench for sram_sched with a behavioural x32 SRAM model on the pins.
module tb_sram_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_sched_if bus();

  logic [17:0] sram_a;
  logic        sram_oe_n, sram_we_n;
  wire  [15:0] sram1_io, sram2_io;
  logic        sram1_ce_n, sram1_ub_n, sram1_lb_n;
  logic        sram2_ce_n, sram2_ub_n, sram2_lb_n;

  sram_sched #(
    .ACCESS_CYCLES(2), .STARVE_LIMIT(8), .VRAM_BASE(18'h38001), .MCR_BASE(18'h30000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sram_a(sram_a), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram1_io(sram1_io), .sram2_io(sram2_io),
    .sram1_ce_n(sram1_ce_n), .sram1_ub_n(sram1_ub_n), .sram1_lb_n(sram1_lb_n),
    .sram2_ce_n(sram2_ce_n), .sram2_ub_n(sram2_ub_n), .sram2_lb_n(sram2_lb_n)
  );

  bit [31:0] mem [0:262143];
  logic      rd_en;
  assign rd_en    = !sram1_ce_n && !sram_oe_n;
  assign sram1_io = rd_en ? mem[sram_a][15:0]  : 16'hzzzz;
  assign sram2_io = rd_en ? mem[sram_a][31:16] : 16'hzzzz;
  always @(posedge clk) if (!sram1_ce_n && !sram_we_n) mem[sram_a] <= {sram2_io, sram1_io};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_t [3];
  int done_n [3];
  int we_cnt = 0;
  always @(negedge clk) begin
    if (bus.vram_done)  begin done_t[0] = cyc; done_n[0]++; end
    if (bus.sdram_done) begin done_t[1] = cyc; done_n[1]++; end
    if (bus.mcr_done)   begin done_t[2] = cyc; done_n[2]++; end
    if (!sram_we_n) we_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.vram_ready && bus.sdram_ready && bus.mcr_ready) && n < limit);
    tick();
    check("settle_budget", 64'(n < limit), 64'(1));
  endtask

  task automatic sd_go(input logic wr, input logic [17:0] a, input logic [31:0] d, output int t);
    bus.sdram_write = wr; bus.sdram_addr = a; bus.sdram_data_in = d; bus.sdram_req = 1'b1;
    tick();
    t = cyc;
    bus.sdram_req = 1'b0;
  endtask

  task automatic mcr_go(input logic wr, input logic [11:0] a, input logic [51:0] d, output int t);
    bus.mcr_write = wr; bus.mcr_addr = a; bus.mcr_data_in = d; bus.mcr_req = 1'b1;
    tick();
    t = cyc;
    bus.mcr_req = 1'b0;
  endtask

  task automatic vr_go(input logic [14:0] a, output int t);
    bus.vram_addr = a; bus.vram_req = 1'b1;
    tick();
    t = cyc;
    bus.vram_req = 1'b0;
  endtask

  initial begin
    int t, tv, n0, lat;
    bus.mcr_addr = '0; bus.mcr_data_in = '0; bus.mcr_req = 1'b0; bus.mcr_write = 1'b0;
    bus.sdram_addr = '0; bus.sdram_data_in = '0; bus.sdram_req = 1'b0; bus.sdram_write = 1'b0;
    bus.vram_addr = '0; bus.vram_req = 1'b0;
    repeat (3) tick();

    check("rst_ready", {61'b0, bus.vram_ready, bus.sdram_ready, bus.mcr_ready}, 64'h7);
    check("rst_done", {61'b0, bus.vram_done, bus.sdram_done, bus.mcr_done}, 64'h0);
    check("rst_strobes", {60'b0, sram1_ce_n, sram2_ce_n, sram_oe_n, sram_we_n}, 64'hF);
    check("rst_ublb", {60'b0, sram1_ub_n, sram1_lb_n, sram2_ub_n, sram2_lb_n}, 64'h0);
    check("rst_addr", 64'(sram_a), 64'h0);
    reset = 1'b0;
    tick();

    // sdram write then read
    we_cnt = 0;
    sd_go(1'b1, 18'h12345, 32'hDEADBEEF, t);
    check("sd_wr_ready_low", 64'(bus.sdram_ready), 64'h0);
    tick();
    check("sd_wr_addr", 64'(sram_a), 64'h12345);
    check("sd_wr_ce", {62'b0, sram1_ce_n, sram2_ce_n}, 64'h0);
    settle(20);
    check("sd_wr_lat", 64'(done_t[1] - t), 64'd3);
    check("sd_wr_mem", 64'(mem[18'h12345]), 64'hDEADBEEF);
    check("sd_wr_we_clocks", 64'(we_cnt), 64'd1);
    n0 = done_n[1];
    sd_go(1'b0, 18'h12345, 32'h0, t);
    bus.sdram_addr = 18'h00777; bus.sdram_req = 1'b1;
    tick();
    bus.sdram_req = 1'b0;
    settle(20);
    check("sd_rd_lat", 64'(done_t[1] - t), 64'd3);
    check("sd_rd_data", 64'(bus.sdram_data_out), 64'hDEADBEEF);
    check("sd_busy_req_ignored", 64'(done_n[1] - n0), 64'd1);

    // mcr write / read, two words each
    sd_go(1'b1, 18'h3000B, 32'hFFFFFFFF, t);
    settle(20);
    we_cnt = 0;
    mcr_go(1'b1, 12'h005, 52'hA_BCDE_F012_3456, t);
    settle(30);
    check("mcr_wr_lat", 64'(done_t[2] - t), 64'd6);
    check("mcr_wr_lo", 64'(mem[18'h3000A]), 64'hF0123456);
    check("mcr_wr_hi", 64'(mem[18'h3000B]), 64'h000ABCDE);
    check("mcr_wr_we_clocks", 64'(we_cnt), 64'd2);
    sd_go(1'b1, 18'h3000B, 32'hFFFABCDE, t);
    settle(20);
    mcr_go(1'b0, 12'h005, 52'h0, t);
    settle(30);
    check("mcr_rd_lat", 64'(done_t[2] - t), 64'd6);
    check("mcr_rd_data", 64'(bus.mcr_data_out), 64'h000A_BCDE_F012_3456);

    // three simultaneous requests straight out of reset
    sd_go(1'b1, 18'h38004, 32'h11223344, t);
    settle(20);
    reset = 1'b1;
    tick();
    tick();
    check("rst2_data", 64'(bus.sdram_data_out | bus.vram_data_out | bus.mcr_data_out[31:0]), 64'h0);
    reset = 1'b0;
    bus.vram_addr = 15'h0003; bus.vram_req = 1'b1;
    bus.sdram_addr = 18'h12345; bus.sdram_write = 1'b0; bus.sdram_req = 1'b1;
    bus.mcr_addr = 12'h005; bus.mcr_write = 1'b0; bus.mcr_req = 1'b1;
    tick();
    t = cyc;
    bus.vram_req = 1'b0; bus.sdram_req = 1'b0; bus.mcr_req = 1'b0;
    settle(40);
    check("arb_vram_lat", 64'(done_t[0] - t), 64'd3);
    check("arb_sdram_lat", 64'(done_t[1] - t), 64'd6);
    check("arb_mcr_lat", 64'(done_t[2] - t), 64'd12);
    check("arb_vram_data", 64'(bus.vram_data_out), 64'h11223344);
    check("arb_sdram_data", 64'(bus.sdram_data_out), 64'hDEADBEEF);
    check("arb_mcr_data", 64'(bus.mcr_data_out), 64'h000A_BCDE_F012_3456);

    // vram under continuous sdram + mcr load
    bus.sdram_addr = 18'h12345; bus.sdram_write = 1'b0; bus.sdram_req = 1'b1;
    bus.mcr_addr = 12'h005; bus.mcr_write = 1'b0; bus.mcr_req = 1'b1;
    repeat (5) tick();
    n0 = done_n[0];
    vr_go(15'h0003, tv);
    lat = 0;
    while (done_n[0] == n0 && lat < 40) begin
      tick();
      lat++;
    end
    check("vram_starve_bound", 64'((done_n[0] != n0) && (done_t[0] - tv <= 16)), 64'h1);
    bus.sdram_req = 1'b0; bus.mcr_req = 1'b0;
    settle(40);

    // reset in the middle of an sdram write
    n0 = done_n[1];
    sd_go(1'b1, 18'h00100, 32'h00000055, t);
    tick();
    check("abort_in_xfer", 64'(sram_we_n), 64'h0);
    reset = 1'b1;
    tick();
    check("abort_strobes", {61'b0, sram1_ce_n, sram_oe_n, sram_we_n}, 64'h7);
    check("abort_ready", 64'(bus.sdram_ready), 64'h1);
    reset = 1'b0;
    repeat (6) tick();
    check("abort_no_done", 64'(done_n[1] - n0), 64'h0);

    // vram address wraps past the top of SRAM
    sd_go(1'b1, 18'h00000, 32'hCAFEF00D, t);
    settle(20);
    vr_go(15'h7FFF, t);
    tick();
    check("vram_wrap_a", 64'(sram_a), 64'h0);
    settle(20);
    check("vram_wrap_lat", 64'(done_t[0] - t), 64'd3);
    check("vram_wrap_data", 64'(bus.vram_data_out), 64'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
